// File: rtl/lc3_pkg.sv
// Shared types and helpers for the LC3 writeback stage: queue entry layout and NZP encoding.
package lc3_pkg;

  typedef struct packed {
    logic [2:0]  dr;
    logic [15:0] data;
    logic        setcc;
  } wb_entry_t;

  localparam logic [2:0] NZP_RESET = 3'b010;

  // Exactly one of {N,Z,P} is set for any 16-bit value.
  function automatic logic [2:0] calc_nzp(input logic [15:0] value);
    if (value[15]) begin
      return 3'b100;
    end else if (value == 16'h0000) begin
      return 3'b010;
    end else begin
      return 3'b001;
    end
  endfunction

endpackage

// File: rtl/lc3_writeback_if.sv
// Handshake and regfile-port bundle of the LC3 writeback stage; WB_FWD_EN adds the forwarding lookup.
interface lc3_writeback_if;

  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_dr;
  logic [15:0] alu_data;
  logic        alu_setcc;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dr;
  logic [15:0] mem_data;
  logic        mem_setcc;
  logic        wb_hold;
  logic        rf_write_en;
  logic [2:0]  rf_sel_in;
  logic [15:0] rf_in_data;
  logic [2:0]  nzp;
  logic [7:0]  busy;
`ifdef WB_FWD_EN
  logic [2:0]  fwd_sel;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  modport master (
    output alu_valid, alu_dr, alu_data, alu_setcc,
    output mem_valid, mem_dr, mem_data, mem_setcc, wb_hold,
`ifdef WB_FWD_EN
    output fwd_sel,
    input  fwd_hit, fwd_data,
`endif
    input  alu_ready, mem_ready, rf_write_en, rf_sel_in, rf_in_data, nzp, busy
  );

  modport slave (
    input  alu_valid, alu_dr, alu_data, alu_setcc,
    input  mem_valid, mem_dr, mem_data, mem_setcc, wb_hold,
`ifdef WB_FWD_EN
    input  fwd_sel,
    output fwd_hit, fwd_data,
`endif
    output alu_ready, mem_ready, rf_write_en, rf_sel_in, rf_in_data, nzp, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order result queue with per-slot valid mask; pointers wrap modulo DEPTH (any DEPTH 1..16).
// WB_FWD_EN exposes slot data and the read pointer for the forwarding lookup.
module wb_fifo
  import lc3_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CW-1:0]    count_o,
  output logic [DEPTH-1:0] slotValid_o,
`ifdef WB_FWD_EN
  output logic [15:0]      slotData_o [DEPTH],
  output logic [PW-1:0]    rdPtr_o,
`endif
  output logic [2:0]       slotDr_o [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Callers never push when full or pop when empty, so push and pop never hit the same slot.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (push_i) begin
      valid_d[wrPtr_q] = 1'b1;
      wrPtr_d          = nextPtr(wrPtr_q);
    end
    if (pop_i) begin
      valid_d[rdPtr_q] = 1'b0;
      rdPtr_d          = nextPtr(rdPtr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= entry_i;
    end
  end

  assign head_o      = mem_q[rdPtr_q];
  assign count_o     = count_q;
  assign slotValid_o = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slotDr_o[i] = mem_q[i].dr;
`ifdef WB_FWD_EN
      slotData_o[i] = mem_q[i].data;
`endif
    end
  end

`ifdef WB_FWD_EN
  assign rdPtr_o = rdPtr_q;
`endif

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: arbitrates ALU/load results into an ordered queue, drives the regfile
// write port, keeps NZP and the pending-write scoreboard. Define WB_FWD_EN for forwarding lookup.
module lc3_writeback
  import lc3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  lc3_writeback_if.slave wb
);

  localparam int CW = $clog2(DEPTH + 1);
`ifdef WB_FWD_EN
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`endif

  logic [CW-1:0]    count;
  wb_entry_t        head;
  wb_entry_t        pushEntry;
  logic             space;
  logic             pushMem;
  logic             pushAlu;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] slotValid;
  logic [2:0]       slotDr [DEPTH];
  logic [2:0]       nzp_q;
`ifdef WB_FWD_EN
  logic [15:0]      slotData [DEPTH];
  logic [PW-1:0]    rdPtr;
`endif

  // Readiness depends on occupancy only, so a same-cycle pop never frees a slot early.
  assign space        = count < CW'(DEPTH);
  assign wb.mem_ready = space && rst_n;
  assign wb.alu_ready = space && !wb.mem_valid && rst_n;
  assign pushMem      = wb.mem_valid && wb.mem_ready;
  assign pushAlu      = wb.alu_valid && wb.alu_ready;
  assign push         = pushMem || pushAlu;

  always_comb begin
    pushEntry = '{dr: wb.alu_dr, data: wb.alu_data, setcc: wb.alu_setcc};
    if (wb.mem_valid) begin
      pushEntry = '{dr: wb.mem_dr, data: wb.mem_data, setcc: wb.mem_setcc};
    end
  end

  assign pop            = (count != '0) && !wb.wb_hold && rst_n;
  assign wb.rf_write_en = pop;
  assign wb.rf_sel_in   = (count != '0) ? head.dr : 3'd0;
  assign wb.rf_in_data  = (count != '0) ? head.data : 16'h0000;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .entry_i    (pushEntry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .slotValid_o(slotValid),
`ifdef WB_FWD_EN
    .slotData_o (slotData),
    .rdPtr_o    (rdPtr),
`endif
    .slotDr_o   (slotDr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nzp_q <= NZP_RESET;
    end else if (pop && head.setcc) begin
      nzp_q <= calc_nzp(head.data);
    end
  end

  assign wb.nzp = nzp_q;

  always_comb begin
    wb.busy = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (slotValid[i]) begin
        wb.busy[slotDr[i]] = 1'b1;
      end
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match left standing is the youngest write.
  always_comb begin
    int          slot;
    logic [PW-1:0] slotIdx;
    slot        = 0;
    slotIdx     = '0;
    wb.fwd_hit  = 1'b0;
    wb.fwd_data = 16'h0000;
    for (int k = 0; k < DEPTH; k++) begin
      slot = int'(rdPtr) + k;
      if (slot >= DEPTH) begin
        slot = slot - DEPTH;
      end
      slotIdx = PW'(slot);
      if (k < int'(count) && slotDr[slotIdx] == wb.fwd_sel) begin
        wb.fwd_hit  = 1'b1;
        wb.fwd_data = slotData[slotIdx];
      end
    end
  end
`endif

endmodule
